// File: rtl/aux_req_arbiter.sv
// AUX channel request arbiter: grants one requester at a time, issues its transaction and
// retries on NACK/DEFER/timeout. Define AUX_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module aux_req_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned RETRY_MAX = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [2*NUM_REQ-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_REQ-1:0] req_address,
  input  logic [LEN_W*NUM_REQ-1:0]  req_len,
  input  logic [1:0]                reply_ack,
  input  logic                      reply_ack_vld,
  input  logic                      timer_timeout,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_failed,
  output logic                      ctrl_tr_vld,
  output logic [1:0]                ctrl_msg_cmd,
  output logic [ADDR_W-1:0]         ctrl_msg_address,
  output logic [LEN_W-1:0]          ctrl_msg_len,
  output logic                      ctrl_native_retrans,
  output logic [2:0]                ctrl_owner_id,
  output logic                      ctrl_busy
);

  localparam int unsigned CntW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RETRY_MAX);
  localparam int NumReq = int'(NUM_REQ);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         owner_q, owner_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] failed_q, failed_d;
  // Blocks arbitration for the single IDLE cycle after reset or after a done/failed pulse.
  logic               hold_q, hold_d;

  logic               win_vld;
  logic [2:0]         win_id;
  logic [1:0]         win_cmd;
  logic [ADDR_W-1:0]  win_addr;
  logic [LEN_W-1:0]   win_len;
  logic               grant;

`ifdef AUX_ARB_ROUND_ROBIN_EN
  logic [2:0] rr_ptr_q;
  int         rr_dist;
  int         rr_best;

  // Winner is the requester at the smallest circular distance past the last grant.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    rr_best = NumReq + 1;
    rr_dist = 0;
    for (int i = 0; i < NumReq; i++) begin
      rr_dist = (i > int'(rr_ptr_q)) ? (i - int'(rr_ptr_q)) : (i + NumReq - int'(rr_ptr_q));
      if (req_vld[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        win_vld = 1'b1;
        win_id  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 3'(NumReq - 1);
    end else if (grant) begin
      rr_ptr_q <= win_id;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        win_vld = 1'b1;
        win_id  = 3'(i);
      end
    end
  end
`endif

  always_comb begin
    win_cmd  = '0;
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (win_id == 3'(i)) begin
        win_cmd  = req_cmd[2*i +: 2];
        win_addr = req_address[ADDR_W*i +: ADDR_W];
        win_len  = req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  assign grant = (state_q == StIdle) && win_vld && !hold_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    len_d    = len_q;
    done_d   = '0;
    failed_d = '0;
    hold_d   = 1'b0;
    req_gnt  = '0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          req_gnt = NUM_REQ'(1) << win_id;
          owner_d = win_id;
          cmd_d   = win_cmd;
          addr_d  = win_addr;
          len_d   = win_len;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // A reply outranks a simultaneous timeout; any non-ACK code counts as a failed attempt.
        if (reply_ack_vld && (reply_ack == 2'b00)) begin
          done_d  = NUM_REQ'(1) << owner_q;
          hold_d  = 1'b1;
          state_d = StIdle;
        end else if (reply_ack_vld || timer_timeout) begin
          if (cnt_q < CntMax) begin
            cnt_d   = cnt_q + CntW'(1);
            state_d = StIssue;
          end else begin
            failed_d = NUM_REQ'(1) << owner_q;
            hold_d   = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      done_q   <= '0;
      failed_q <= '0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      done_q   <= done_d;
      failed_q <= failed_d;
      hold_q   <= hold_d;
    end
  end

  assign req_done            = done_q;
  assign req_failed          = failed_q;
  assign ctrl_tr_vld         = (state_q == StIssue);
  assign ctrl_native_retrans = (state_q == StIssue) && (cnt_q != '0);
  assign ctrl_busy           = (state_q != StIdle);
  assign ctrl_owner_id       = owner_q;
  assign ctrl_msg_cmd        = cmd_q;
  assign ctrl_msg_address    = addr_q;
  assign ctrl_msg_len        = len_q;

endmodule

// File: tb/tb_aux_req_arbiter.sv
// Self-checking bench for aux_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model. Honours AUX_ARB_ROUND_ROBIN_EN like the design.
module tb_aux_req_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 20;
  localparam int LEN_W     = 8;
  localparam int RETRY_MAX = 7;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_vld;
  logic [2*NUM_REQ-1:0]      req_cmd;
  logic [ADDR_W*NUM_REQ-1:0] req_address;
  logic [LEN_W*NUM_REQ-1:0]  req_len;
  logic [1:0]                reply_ack;
  logic                      reply_ack_vld;
  logic                      timer_timeout;
  logic [NUM_REQ-1:0]        req_gnt;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_failed;
  logic                      ctrl_tr_vld;
  logic [1:0]                ctrl_msg_cmd;
  logic [ADDR_W-1:0]         ctrl_msg_address;
  logic [LEN_W-1:0]          ctrl_msg_len;
  logic                      ctrl_native_retrans;
  logic [2:0]                ctrl_owner_id;
  logic                      ctrl_busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int last_gnt     = NUM_REQ - 1;

  logic [1:0]        f_cmd  [NUM_REQ];
  logic [ADDR_W-1:0] f_addr [NUM_REQ];
  logic [LEN_W-1:0]  f_len  [NUM_REQ];

  aux_req_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_vld            (req_vld),
    .req_cmd            (req_cmd),
    .req_address        (req_address),
    .req_len            (req_len),
    .reply_ack          (reply_ack),
    .reply_ack_vld      (reply_ack_vld),
    .timer_timeout      (timer_timeout),
    .req_gnt            (req_gnt),
    .req_done           (req_done),
    .req_failed         (req_failed),
    .ctrl_tr_vld        (ctrl_tr_vld),
    .ctrl_msg_cmd       (ctrl_msg_cmd),
    .ctrl_msg_address   (ctrl_msg_address),
    .ctrl_msg_len       (ctrl_msg_len),
    .ctrl_native_retrans(ctrl_native_retrans),
    .ctrl_owner_id      (ctrl_owner_id),
    .ctrl_busy          (ctrl_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cmd[2*i +: 2]               = f_cmd[i];
      req_address[ADDR_W*i +: ADDR_W] = f_addr[i];
      req_len[LEN_W*i +: LEN_W]       = f_len[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NUM_REQ; i++) begin
      f_cmd[i]  = 2'($urandom);
      f_addr[i] = ADDR_W'($urandom);
      f_len[i]  = LEN_W'($urandom);
    end
    drive_fields();
  endtask

  // Arbitration rule from the requirements, not from the RTL structure.
  function automatic int model_winner(input logic [NUM_REQ-1:0] vld);
    int   w;
    logic found;
    w     = -1;
    found = 1'b0;
`ifdef AUX_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && vld[(last_gnt + k) % NUM_REQ]) begin
        w     = (last_gnt + k) % NUM_REQ;
        found = 1'b1;
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && vld[i]) begin
        w     = i;
        found = 1'b1;
      end
    end
`endif
    return w;
  endfunction

  // kind: 0 random bad replies, 1 DEFER, 2 timeout, 3 final ACK with simultaneous timeout.
  task automatic run_txn(input logic [NUM_REQ-1:0] vld, input int n_bad, input int kind,
                         input logic churn, input string tag);
    int                 w;
    int                 strobes;
    int                 exp_strobes;
    int                 r;
    logic               exp_done;
    logic               finished;
    logic [NUM_REQ-1:0] oh;
    logic [1:0]         e_cmd;
    logic [ADDR_W-1:0]  e_addr;
    logic [LEN_W-1:0]   e_len;

    w           = model_winner(vld);
    oh          = NUM_REQ'(1) << w;
    exp_done    = (n_bad <= RETRY_MAX);
    exp_strobes = exp_done ? n_bad + 1 : RETRY_MAX + 1;
    e_cmd       = f_cmd[w];
    e_addr      = f_addr[w];
    e_len       = f_len[w];

    req_vld = vld;
    drive_fields();
    @(negedge clk);
    check({tag, "/gnt"}, 32'(req_gnt), 32'(oh));
    check({tag, "/busy_idle"}, 32'(ctrl_busy), 32'd0);
    last_gnt = w;
    @(posedge clk); #1;
    if (churn) begin
      req_vld = NUM_REQ'($urandom);
      rand_fields();
    end

    strobes  = 0;
    finished = 1'b0;
    for (int a = 0; a <= RETRY_MAX && !finished; a++) begin
      // Issue cycle: a stray reply here must be ignored.
      if (kind == 0 && $urandom_range(0, 3) == 0) begin
        reply_ack_vld = 1'b1;
        reply_ack     = 2'b00;
        timer_timeout = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (ctrl_tr_vld) strobes++;
      check({tag, "/tr_vld"}, 32'(ctrl_tr_vld), 32'd1);
      check({tag, "/retrans"}, 32'(ctrl_native_retrans), 32'(a > 0));
      check({tag, "/addr"}, 32'(ctrl_msg_address), 32'(e_addr));
      check({tag, "/cmd_len"}, {22'd0, ctrl_msg_cmd, ctrl_msg_len}, {22'd0, e_cmd, e_len});
      check({tag, "/owner"}, 32'(ctrl_owner_id), 32'(w));
      check({tag, "/no_gnt_busy"}, {30'd0, |req_gnt, ctrl_busy}, 32'd1);
      @(posedge clk); #1;
      reply_ack_vld = 1'b0;
      timer_timeout = 1'b0;

      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        if (ctrl_tr_vld) strobes++;
        check({tag, "/wait_quiet"}, {30'd0, ctrl_tr_vld, ctrl_busy}, 32'd1);
        @(posedge clk); #1;
      end

      if (a < n_bad) begin
        r = (kind == 1) ? 1 : (kind == 2) ? 3 : int'($urandom_range(0, 3));
        case (r)
          0:       begin reply_ack_vld = 1'b1; reply_ack = 2'b01; end
          1:       begin reply_ack_vld = 1'b1; reply_ack = 2'b10; end
          2:       begin reply_ack_vld = 1'b1; reply_ack = 2'b11; end
          default: timer_timeout = 1'b1;
        endcase
        if (r < 3 && kind == 0) timer_timeout = 1'($urandom_range(0, 1));
      end else begin
        reply_ack_vld = 1'b1;
        reply_ack     = 2'b00;
        timer_timeout = (kind == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (a >= n_bad || a == RETRY_MAX) finished = 1'b1;
      @(negedge clk);
      if (ctrl_tr_vld) strobes++;
      check({tag, "/reply_cycle"}, {30'd0, ctrl_tr_vld, ctrl_busy}, 32'd1);
      @(posedge clk); #1;
      reply_ack_vld = 1'b0;
      timer_timeout = 1'b0;
    end

    @(negedge clk);
    check({tag, "/done"}, 32'(req_done), exp_done ? 32'(oh) : 32'd0);
    check({tag, "/failed"}, 32'(req_failed), exp_done ? 32'd0 : 32'(oh));
    check({tag, "/end_idle"}, {29'd0, |req_gnt, ctrl_busy, ctrl_tr_vld}, 32'd0);
    check({tag, "/strobes"}, 32'(strobes), 32'(exp_strobes));
    @(posedge clk); #1;
    req_vld = '0;
  endtask

  initial begin
    rst_n         = 1'b0;
    req_vld       = '1;
    reply_ack     = 2'b00;
    reply_ack_vld = 1'b0;
    timer_timeout = 1'b0;
    rand_fields();
    @(posedge clk); #1;
    @(negedge clk);
    check("reset/pulses", {req_gnt, req_done, req_failed}, 32'd0);
    check("reset/ctrl", {27'd0, ctrl_tr_vld, ctrl_native_retrans, ctrl_busy, 2'd0}, 32'd0);
    check("reset/fields", {ctrl_msg_cmd, ctrl_msg_len, ctrl_msg_address}, 32'd0);
    check("reset/owner", 32'(ctrl_owner_id), 32'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    req_vld = '0;
    @(posedge clk); #1;

    // Single ACKed transaction with known fields.
    rand_fields();
    f_cmd[0]  = 2'b01;
    f_addr[0] = 20'h00202;
    f_len[0]  = 8'd1;
    run_txn(4'b0001, 0, 1, 1'b0, "basic_ack");

    rand_fields();
    run_txn(4'b0010, 3, 1, 1'b1, "defer3");
    rand_fields();
    run_txn(4'b0100, 8, 2, 1'b1, "timeout8");

    // All requesters held high.
    for (int n = 0; n < 5; n++) begin
      rand_fields();
      run_txn(4'b1111, 0, 0, 1'b0, "held_all");
    end

    rand_fields();
    run_txn(4'b1000, 0, 3, 1'b0, "ack_and_timeout");

    // Reset while waiting for a reply abandons the transaction silently.
    rand_fields();
    req_vld = 4'b0100;
    drive_fields();
    @(negedge clk);
    check("rst_wait/gnt", 32'(req_gnt), 32'(4'(model_winner(4'b0100) >= 0) << model_winner(4'b0100)));
    @(posedge clk); #1;
    req_vld = '0;
    @(negedge clk);
    check("rst_wait/issue", 32'(ctrl_tr_vld), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    last_gnt = NUM_REQ - 1;
    check("rst_wait/pulses", {req_gnt, req_done, req_failed}, 32'd0);
    check("rst_wait/ctrl", {29'd0, ctrl_tr_vld, ctrl_native_retrans, ctrl_busy}, 32'd0);
    check("rst_wait/fields", {ctrl_msg_cmd, ctrl_msg_len, ctrl_msg_address}, 32'd0);
    check("rst_wait/owner", 32'(ctrl_owner_id), 32'd0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    reply_ack_vld = 1'b1;
    reply_ack     = 2'b00;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("rst_wait/silent", {28'd0, req_done, req_failed} == 32'd0 ? 32'd0 : 32'd1, 32'd0);
      check("rst_wait/idle", 32'(ctrl_busy), 32'd0);
      @(posedge clk); #1;
      reply_ack_vld = 1'b0;
    end
    rand_fields();
    run_txn(4'b0110, 1, 0, 1'b1, "after_reset");

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      logic [NUM_REQ-1:0] v;
      v = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      rand_fields();
      run_txn(v, int'($urandom_range(0, RETRY_MAX + 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
